peach_motion: RTL and testbench

Sprite position and motion controller for the Peach player sprite. It moves the sprite tile-by-tile through a 32×24 maze grid of 20×20 px tiles, driven by keyboard keycodes. It checks the destination tile against the maze wall map and animates each move over several frames. Per pixel, it converts the VGA scan position into sprite-relative `Sprite_dx`/`Sprite_dy` plus a `sprite_on` qualifier, which feed the Peach sprite renderer directly downstream.

---
 rtl/peach_pkg.sv | 48 ++++
 rtl/peach_motion_frame_tick.sv | 26 ++
 rtl/peach_motion.sv | 179 +++++++++++++++++
 tb/tb_peach_motion.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peach_pkg.sv
// Shared types and constants for the Peach sprite motion controller.
// Pure declarations; no state, so no latency or backpressure of its own.
package peach_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        MOVE  = 2'd2
    } motion_state_t;

    localparam int TILE_PX   = 20;
    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 24;
    localparam int SPRITE_W  = 20;
    localparam int SPRITE_H  = 25;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] kc);
        key_t k;
        k.vld = 1'b1;
        k.dir = DOWN;
        case (kc)
            KEY_W:   k.dir = UP;
            KEY_S:   k.dir = DOWN;
            KEY_A:   k.dir = LEFT;
            KEY_D:   k.dir = RIGHT;
            default: k.vld = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/peach_motion_frame_tick.sv
// One-cycle tick per frame from the falling edge of the registered vsync.
// Latency: tick is high the cycle after the registered vsync drops; no backpressure.
module frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;
    logic vsync_prev_q;

    // Reset low so a vsync that is already high after reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
        end
    end

    assign tick = vsync_prev_q & ~vsync_q;

endmodule

// File: rtl/peach_motion.sv
// Tile-by-tile sprite mover with wall lookup, plus registered sprite-relative pixel offsets.
// Latency: pixel outputs 1 cycle; decisions on frame tick +1, wall answer +1; no backpressure.
module peach_motion
    import peach_pkg::*;
#(
    parameter int START_COL = 1,
    parameter int START_ROW = 1,
    parameter int STEP_PX   = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic [7:0]  keycode,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [4:0]  query_col,
    output logic [4:0]  query_row,
    input  logic        query_wall,
    output logic [19:0] Sprite_dx,
    output logic [19:0] Sprite_dy,
    output logic        sprite_on,
    output logic [1:0]  facing,
    output logic        moving,
    output logic [4:0]  tile_col,
    output logic [4:0]  tile_row
);

    localparam logic [9:0] STEP    = 10'(STEP_PX);
    localparam logic [4:0] N_LAST  = 5'(TILE_PX / STEP_PX - 1);
    localparam logic [9:0] START_X = 10'(START_COL * TILE_PX);
    localparam logic [9:0] START_Y = 10'(START_ROW * TILE_PX);

    logic tick;

    frame_tick u_frame_tick (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .vsync (vsync),
        .tick  (tick)
    );

    motion_state_t state_q, state_d;
    dir_t          facing_q, facing_d;
    logic [4:0]    tile_col_q, tile_col_d, tile_row_q, tile_row_d;
    logic [4:0]    query_col_q, query_col_d, query_row_q, query_row_d;
    logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [4:0]    step_cnt_q, step_cnt_d;
    logic          moving_q, moving_d;
    logic [19:0]   sprite_dx_q, sprite_dx_d, sprite_dy_q, sprite_dy_d;
    logic          sprite_on_q, sprite_on_d;

    key_t       key;
    logic       tgt_ok;
    logic [4:0] tgt_col, tgt_row;
    logic [10:0] dx, dy;
    logic       pix_on;

    always_comb begin
        key     = decode_key(keycode);
        tgt_ok  = 1'b0;
        tgt_col = tile_col_q;
        tgt_row = tile_row_q;
        case (key.dir)
            UP:    begin tgt_ok = (tile_row_q != 5'd0);               tgt_row = tile_row_q - 5'd1; end
            DOWN:  begin tgt_ok = (tile_row_q != 5'(GRID_ROWS - 1));  tgt_row = tile_row_q + 5'd1; end
            LEFT:  begin tgt_ok = (tile_col_q != 5'd0);               tgt_col = tile_col_q - 5'd1; end
            RIGHT: begin tgt_ok = (tile_col_q != 5'(GRID_COLS - 1));  tgt_col = tile_col_q + 5'd1; end
            default: tgt_ok = 1'b0;
        endcase
    end

    // The query registers double as the move target: they hold it through MOVE.
    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        tile_col_d  = tile_col_q;
        tile_row_d  = tile_row_q;
        query_col_d = query_col_q;
        query_row_d = query_row_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        step_cnt_d  = step_cnt_q;
        moving_d    = moving_q;
        case (state_q)
            IDLE: begin
                if (tick && key.vld) begin
                    facing_d = key.dir;
                    if (tgt_ok) begin
                        query_col_d = tgt_col;
                        query_row_d = tgt_row;
                        state_d     = QUERY;
                    end
                end
            end
            QUERY: begin
                if (query_wall) begin
                    state_d = IDLE;
                end else begin
                    state_d    = MOVE;
                    moving_d   = 1'b1;
                    step_cnt_d = 5'd0;
                end
            end
            MOVE: begin
                if (tick) begin
                    case (facing_q)
                        UP:      pos_y_d = pos_y_q - STEP;
                        DOWN:    pos_y_d = pos_y_q + STEP;
                        LEFT:    pos_x_d = pos_x_q - STEP;
                        default: pos_x_d = pos_x_q + STEP;
                    endcase
                    step_cnt_d = step_cnt_q + 5'd1;
                    if (step_cnt_q == N_LAST) begin
                        tile_col_d = query_col_q;
                        tile_row_d = query_row_q;
                        step_cnt_d = 5'd0;
                        moving_d   = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A negative offset shows up as bit 10 set, which rejects it before the range test.
    always_comb begin
        dx          = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy          = {1'b0, DrawY} - {1'b0, pos_y_q};
        pix_on      = !dx[10] && (dx[9:0] < 10'(SPRITE_W)) &&
                      !dy[10] && (dy[9:0] < 10'(SPRITE_H));
        sprite_on_d = pix_on;
        sprite_dx_d = pix_on ? 20'(dx[9:0]) : 20'd0;
        sprite_dy_d = pix_on ? 20'(dy[9:0]) : 20'd0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            facing_q    <= DOWN;
            tile_col_q  <= 5'(START_COL);
            tile_row_q  <= 5'(START_ROW);
            query_col_q <= 5'd0;
            query_row_q <= 5'd0;
            pos_x_q     <= START_X;
            pos_y_q     <= START_Y;
            step_cnt_q  <= 5'd0;
            moving_q    <= 1'b0;
            sprite_dx_q <= 20'd0;
            sprite_dy_q <= 20'd0;
            sprite_on_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            tile_col_q  <= tile_col_d;
            tile_row_q  <= tile_row_d;
            query_col_q <= query_col_d;
            query_row_q <= query_row_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            step_cnt_q  <= step_cnt_d;
            moving_q    <= moving_d;
            sprite_dx_q <= sprite_dx_d;
            sprite_dy_q <= sprite_dy_d;
            sprite_on_q <= sprite_on_d;
        end
    end

    assign query_col = query_col_q;
    assign query_row = query_row_q;
    assign Sprite_dx = sprite_dx_q;
    assign Sprite_dy = sprite_dy_q;
    assign sprite_on = sprite_on_q;
    assign facing    = facing_q;
    assign moving    = moving_q;
    assign tile_col  = tile_col_q;
    assign tile_row  = tile_row_q;

endmodule

// File: tb/tb_peach_motion.sv
// Bench for peach_motion: pixel-window table, directed move/wall/edge/reset sequences,
// then random keys and walls against a frame-level model of tiles, facing and pixel position.
module tb_peach_motion;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync   = 1'b1;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  DrawX   = 10'd0;
    logic [9:0]  DrawY   = 10'd0;
    logic        query_wall;
    logic [4:0]  query_col, query_row, tile_col, tile_row;
    logic [19:0] Sprite_dx, Sprite_dy;
    logic        sprite_on, moving;
    logic [1:0]  facing;

    logic wall_map [32][32];

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model
    int m_col, m_row, m_face, m_moving, m_steps, m_qc, m_qr;

    typedef struct {
        int x;
        int y;
        int on;
        int dx;
        int dy;
    } pix_vec_t;

    always #20 vga_clk = ~vga_clk;

    assign query_wall = wall_map[query_row][query_col];

    peach_motion #(.START_COL(1), .START_ROW(1), .STEP_PX(2)) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .keycode    (keycode),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .query_col  (query_col),
        .query_row  (query_row),
        .query_wall (query_wall),
        .Sprite_dx  (Sprite_dx),
        .Sprite_dy  (Sprite_dy),
        .sprite_on  (sprite_on),
        .facing     (facing),
        .moving     (moving),
        .tile_col   (tile_col),
        .tile_row   (tile_row)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int m_px();
        int v;
        v = 0;
        if (m_moving != 0 && m_face == 2) v = -2 * m_steps;
        if (m_moving != 0 && m_face == 3) v = 2 * m_steps;
        return m_col * 20 + v;
    endfunction

    function automatic int m_py();
        int v;
        v = 0;
        if (m_moving != 0 && m_face == 0) v = -2 * m_steps;
        if (m_moving != 0 && m_face == 1) v = 2 * m_steps;
        return m_row * 20 + v;
    endfunction

    task automatic model_reset();
        m_col = 1; m_row = 1; m_face = 1; m_moving = 0; m_steps = 0; m_qc = 0; m_qr = 0;
    endtask

    // One frame tick: finish or advance a move, otherwise act on the held key.
    task automatic model_tick();
        int d, tc, tr;
        if (m_moving != 0) begin
            m_steps++;
            if (m_steps == 10) begin
                m_col = m_qc; m_row = m_qr; m_moving = 0; m_steps = 0;
            end
        end else begin
            d = key_dir(keycode);
            if (d >= 0) begin
                m_face = d;
                tc = m_col + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
                tr = m_row + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
                if (tc >= 0 && tc < 32 && tr >= 0 && tr < 24) begin
                    m_qc = tc; m_qr = tr;
                    if (wall_map[tr][tc] == 1'b0) begin
                        m_moving = 1; m_steps = 0;
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at a negedge after the frame has settled.
    task automatic run_frame();
        vsync = 1'b0;
        repeat (4) @(negedge vga_clk);
        vsync = 1'b1;
        repeat (8) @(negedge vga_clk);
        model_tick();
    endtask

    task automatic check_state();
        chk("tile_col", int'(tile_col), m_col);
        chk("tile_row", int'(tile_row), m_row);
        chk("facing", int'(facing), m_face);
        chk("moving", int'(moving), m_moving);
        chk("query_col", int'(query_col), m_qc);
        chk("query_row", int'(query_row), m_qr);
    endtask

    task automatic check_pix(input int x, input int y);
        int ex, ey, on;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge vga_clk);
        ex = x - m_px();
        ey = y - m_py();
        on = (ex >= 0 && ex < 20 && ey >= 0 && ey < 25) ? 1 : 0;
        chk("sprite_on", int'(sprite_on), on);
        chk("Sprite_dx", int'(Sprite_dx), (on != 0) ? ex : 0);
        chk("Sprite_dy", int'(Sprite_dy), (on != 0) ? ey : 0);
    endtask

    task automatic do_move(input logic [7:0] k);
        keycode = k;
        run_frame();
        check_state();
        keycode = 8'h00;
        repeat (10) begin
            run_frame();
            check_state();
        end
    endtask

    initial begin
        pix_vec_t tbl[8];
        logic [7:0] keys[6];
        tbl[0] = '{25, 30, 1, 5, 10};
        tbl[1] = '{20, 20, 1, 0, 0};
        tbl[2] = '{39, 44, 1, 19, 24};
        tbl[3] = '{40, 30, 0, 0, 0};
        tbl[4] = '{19, 30, 0, 0, 0};
        tbl[5] = '{25, 45, 0, 0, 0};
        tbl[6] = '{25, 19, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0};
        keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h04;
        keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                wall_map[r][c] = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check_state();
        chk("reset sprite_on", int'(sprite_on), 0);
        chk("reset Sprite_dx", int'(Sprite_dx), 0);

        // Pixel window at pos (20,20)
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(tbl[i].x);
            DrawY = 10'(tbl[i].y);
            @(negedge vga_clk);
            chk("tbl sprite_on", int'(sprite_on), tbl[i].on);
            chk("tbl Sprite_dx", int'(Sprite_dx), tbl[i].dx);
            chk("tbl Sprite_dy", int'(Sprite_dy), tbl[i].dy);
        end

        // Open move right: one query to (2,1), then ten 2-px steps
        keycode = 8'h07;
        run_frame();
        keycode = 8'h00;
        chk("move query_col", int'(query_col), 2);
        chk("move query_row", int'(query_row), 1);
        chk("move moving", int'(moving), 1);
        chk("move facing", int'(facing), 3);
        for (int k = 1; k <= 10; k++) begin
            run_frame();
            check_state();
            DrawX = 10'(20 + 2 * k);
            DrawY = 10'd20;
            @(negedge vga_clk);
            chk("step left edge on", int'(sprite_on), 1);
            chk("step left edge dx", int'(Sprite_dx), 0);
            DrawX = 10'(19 + 2 * k);
            @(negedge vga_clk);
            chk("step outside off", int'(sprite_on), 0);
        end
        chk("move tile_col", int'(tile_col), 2);
        chk("move done moving", int'(moving), 0);

        // Pixel window at pos (40,20)
        DrawX = 10'd60; DrawY = 10'd30;
        @(negedge vga_clk);
        chk("win60 sprite_on", int'(sprite_on), 0);
        chk("win60 Sprite_dx", int'(Sprite_dx), 0);
        chk("win60 Sprite_dy", int'(Sprite_dy), 0);
        DrawX = 10'd59; DrawY = 10'd44;
        @(negedge vga_clk);
        chk("win59 sprite_on", int'(sprite_on), 1);
        chk("win59 Sprite_dx", int'(Sprite_dx), 19);
        chk("win59 Sprite_dy", int'(Sprite_dy), 24);

        // Wall above (2,1)
        wall_map[0][2] = 1'b1;
        keycode = 8'h1A;
        run_frame();
        keycode = 8'h00;
        chk("wall facing", int'(facing), 0);
        chk("wall moving", int'(moving), 0);
        chk("wall tile_col", int'(tile_col), 2);
        chk("wall tile_row", int'(tile_row), 1);
        run_frame();
        check_state();
        check_pix(40, 20);

        // Walk to (0,0), then push left into the grid edge
        do_move(8'h04);
        do_move(8'h04);
        do_move(8'h1A);
        chk("corner tile_col", int'(tile_col), 0);
        chk("corner tile_row", int'(tile_row), 0);
        keycode = 8'h04;
        run_frame();
        keycode = 8'h00;
        chk("edge facing", int'(facing), 2);
        chk("edge moving", int'(moving), 0);
        chk("edge query_col", int'(query_col), 0);
        chk("edge tile_col", int'(tile_col), 0);
        run_frame();
        check_state();

        // Reset on the 5th move tick
        keycode = 8'h07;
        run_frame();
        keycode = 8'h00;
        repeat (4) run_frame();
        vsync = 1'b0;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midreset tile_col", int'(tile_col), 1);
        chk("midreset tile_row", int'(tile_row), 1);
        chk("midreset moving", int'(moving), 0);
        chk("midreset facing", int'(facing), 1);
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        vsync = 1'b1;
        repeat (3) @(negedge vga_clk);
        check_state();
        check_pix(20, 20);

        // Random walls and keys
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 32; c++)
                wall_map[r][c] = ($urandom_range(0, 3) == 0);
        wall_map[1][1] = 1'b0;
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 2) != 0)
                keycode = keys[$urandom_range(0, 5)];
            run_frame();
            check_state();
            check_pix(m_px() + $urandom_range(0, 25) - 3, m_py() + $urandom_range(0, 30) - 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
